// File: rtl/dmem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_stage_pkg
//  Description : Shared definitions for the data-memory stage: opcode and
//                funct3 encodings, FSM state and fault enums, and the
//                legality check applied when an op is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_stage_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   typedef enum logic [1:0] {
      FLT_NONE     = 2'd0,
      FLT_MISALIGN = 2'd1,
      FLT_ILLEGAL  = 2'd2
   } dmem_fault_t;

   // Classifies an op; an illegal encoding wins over a misaligned address.
   // funct3[1:0] encodes the access width (00 byte, 01 half, 10 word).
   function automatic dmem_fault_t dmem_check(
      input logic [6:0] opcode,
      input logic [2:0] funct3,
      input logic [1:0] ea_lo
   );
      logic illegal;
      logic misalign;
      if (opcode == OP_LOAD) begin
         illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      end else if (opcode == OP_STORE) begin
         illegal = !(funct3 inside {F3_B, F3_H, F3_W});
      end else begin
         illegal = 1'b1;
      end
      misalign = ((funct3[1:0] == 2'b01) && ea_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (ea_lo != 2'b00));
      if (illegal) begin
         return FLT_ILLEGAL;
      end else if (misalign) begin
         return FLT_MISALIGN;
      end
      return FLT_NONE;
   endfunction

endpackage : dmem_stage_pkg
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_align
//  Description : Combinational byte-lane logic for a 32-bit data port.
//                Store direction: byte enables and lane-shifted write data.
//                Load direction : lane extraction with sign/zero extension.
//                Kept standalone so a future cache can reuse it.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_align
   import dmem_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_offset,
   input  logic [XLEN-1:0] i_st_data,
   input  logic [XLEN-1:0] i_rdata,
   output logic [3:0]      o_be,
   output logic [XLEN-1:0] o_wdata,
   output logic [XLEN-1:0] o_ld_data
);

   logic [4:0]  w_shamt;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_shamt = {i_offset, 3'b000};

   // Store lanes: enables follow the access width, data moves to its lane.
   always_comb begin
      o_wdata = i_st_data << w_shamt;
      case (i_funct3[1:0])
         2'b00:   o_be = 4'b0001 << i_offset;
         2'b01:   o_be = 4'b0011 << i_offset;
         default: o_be = 4'b1111;
      endcase
   end

   // Load lanes: halfwords are only ever legal on offset 0 or 2, so only
   // offset[1] selects the half and the part-select stays in range.
   always_comb begin
      w_byte = i_rdata[w_shamt +: 8];
      w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
      case (i_funct3)
         F3_B:    o_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_BU:   o_ld_data = {{(XLEN-8){1'b0}}, w_byte};
         F3_H:    o_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
         F3_HU:   o_ld_data = {{(XLEN-16){1'b0}}, w_half};
         default: o_ld_data = i_rdata;
      endcase
   end

endmodule : dmem_align
`default_nettype wire

// File: rtl/dmem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_stage
//  Description : Data-memory stage. Accepts one decoded LOAD/STORE at a time,
//                computes rs1 + sext(imm12), checks legality, runs a single
//                request/ack memory transaction and returns an aligned,
//                extended result to writeback over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_stage
   import dmem_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   // decode side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [4:0]        in_rd,
   input  logic [XLEN-1:0]   in_rs1_val,
   input  logic [XLEN-1:0]   in_rs2_val,
   input  logic [11:0]       in_imm,
   // data-memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata,
   // writeback side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_rd,
   output logic [XLEN-1:0]   out_rd_value,
   output logic              out_we,
   output logic [1:0]        out_fault
);

   dmem_state_t       r_state;
   dmem_state_t       w_state_nxt;

   logic [XLEN-1:0]   w_ea;
   dmem_fault_t       w_fault;
   logic              w_accept;
   logic              w_is_load;
   logic              w_is_store;

   // Op attributes kept for the load-return path.
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic              r_is_load;

   // Lane logic is shared between accept (store packing) and ack (load
   // extraction); these two never happen in the same state.
   logic [2:0]        w_al_funct3;
   logic [1:0]        w_al_off;
   logic [3:0]        w_be;
   logic [XLEN-1:0]   w_wdata;
   logic [XLEN-1:0]   w_ld_data;

   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [3:0]        r_mem_be;
   logic [XLEN-1:0]   r_mem_wdata;
   logic [4:0]        r_out_rd;
   logic [XLEN-1:0]   r_out_rd_value;
   logic              r_out_we;
   dmem_fault_t       r_out_fault;

   assign w_ea       = in_rs1_val + {{(XLEN-12){in_imm[11]}}, in_imm};
   assign w_fault    = dmem_check(in_opcode, in_funct3, w_ea[1:0]);
   assign w_accept   = in_valid & in_ready;
   assign w_is_load  = (in_opcode == OP_LOAD);
   assign w_is_store = (in_opcode == OP_STORE);

   assign w_al_funct3 = (r_state == IDLE) ? in_funct3  : r_funct3;
   assign w_al_off    = (r_state == IDLE) ? w_ea[1:0]  : r_off;

   dmem_align #(
      .XLEN (XLEN)
   ) u_align (
      .i_funct3  (w_al_funct3),
      .i_offset  (w_al_off),
      .i_st_data (in_rs2_val),
      .i_rdata   (mem_rdata),
      .o_be      (w_be),
      .o_wdata   (w_wdata),
      .o_ld_data (w_ld_data)
   );

   // Handshake flags decode straight from the state register so that an
   // asynchronous reset drops mem_req and out_valid immediately.
   assign in_ready     = (r_state == IDLE);
   assign mem_req      = (r_state == REQ);
   assign out_valid    = (r_state == RESP);
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_be       = r_mem_be;
   assign mem_wdata    = r_mem_wdata;
   assign out_rd       = r_out_rd;
   assign out_rd_value = r_out_rd_value;
   assign out_we       = r_out_we;
   assign out_fault    = r_out_fault;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: faulting ops skip the memory port and report directly.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = (w_fault == FLT_NONE) ? REQ : RESP;
            end
         end
         REQ: begin
            if (mem_ack) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Op latch at accept and load-data capture on the ack edge. Everything
   // here is only written in IDLE or on ack, so outputs hold in REQ/RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_funct3       <= 3'b000;
         r_off          <= 2'b00;
         r_is_load      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_be       <= 4'b0000;
         r_mem_wdata    <= '0;
         r_out_rd       <= 5'd0;
         r_out_rd_value <= '0;
         r_out_we       <= 1'b0;
         r_out_fault    <= FLT_NONE;
      end else if (w_accept) begin
         r_funct3       <= in_funct3;
         r_off          <= w_ea[1:0];
         r_is_load      <= w_is_load;
         r_out_rd       <= in_rd;
         r_out_rd_value <= '0;
         r_out_fault    <= w_fault;
         if (w_fault == FLT_NONE) begin
            r_mem_we    <= w_is_store;
            r_mem_addr  <= {w_ea[ADDR_W-1:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_is_store ? w_wdata : '0;
            r_out_we    <= w_is_load && (in_rd != 5'd0);
         end else begin
            r_out_we    <= 1'b0;
         end
      end else if ((r_state == REQ) && mem_ack && r_is_load) begin
         r_out_rd_value <= w_ld_data;
      end
   end

endmodule : dmem_stage
`default_nettype wire

// File: tb/tb_dmem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_stage
//  Description : Self-checking bench for dmem_stage with a queue scoreboard of
//                expected memory requests and writeback results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_stage;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        in_opcode;
   logic [2:0]        in_funct3;
   logic [4:0]        in_rd;
   logic [XLEN-1:0]   in_rs1_val;
   logic [XLEN-1:0]   in_rs2_val;
   logic [11:0]       in_imm;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_ack;
   logic [XLEN-1:0]   mem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [4:0]        out_rd;
   logic [XLEN-1:0]   out_rd_value;
   logic              out_we;
   logic [1:0]        out_fault;

   always #5 clk = ~clk;

   dmem_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_funct3    (in_funct3),
      .in_rd        (in_rd),
      .in_rs1_val   (in_rs1_val),
      .in_rs2_val   (in_rs2_val),
      .in_imm       (in_imm),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rd       (out_rd),
      .out_rd_value (out_rd_value),
      .out_we       (out_we),
      .out_fault    (out_fault)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] value;
      logic        we;
      logic [1:0]  fault;
      logic        chk_value;
   } out_exp_t;

   mem_exp_t mem_q[$];
   out_exp_t out_q[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference legality: illegal first, then width-vs-alignment.
   function automatic logic [1:0] model_fault(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [31:0] ea);
      logic bad;
      case (op)
         7'b0000011: bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         7'b0100011: bad = (f3 > 3'd2);
         default:    bad = 1'b1;
      endcase
      if (bad) return 2'd2;
      if ((f3[1:0] == 2'd1) && ea[0]) return 2'd1;
      if ((f3[1:0] == 2'd2) && (ea[1:0] != 2'd0)) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd_word);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rd_word[7:0];
         2'd1:    b = rd_word[15:8];
         2'd2:    b = rd_word[23:16];
         default: b = rd_word[31:24];
      endcase
      h = off[1] ? rd_word[31:16] : rd_word[15:0];
      case (f3)
         3'd0:    return {{24{b[7]}}, b};
         3'd4:    return {24'h0, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd5:    return {16'h0, h};
         default: return rd_word;
      endcase
   endfunction

   // One complete transaction: drive, predict, follow REQ and RESP.
   task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm,
                         input logic [31:0] rdata, input int ack_wait, input int ready_wait);
      logic [31:0] ea;
      logic [1:0]  flt;
      logic        is_load;
      mem_exp_t    me;
      out_exp_t    oe;

      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      in_valid   = 1'b1;
      in_opcode  = op;
      in_funct3  = f3;
      in_rd      = rd;
      in_rs1_val = rs1;
      in_rs2_val = rs2;
      in_imm     = imm;

      ea      = rs1 + {{20{imm[11]}}, imm};
      flt     = model_fault(op, f3, ea);
      is_load = (op == 7'b0000011);
      if (flt == 2'd0) begin
         me.we    = !is_load;
         me.addr  = {ea[31:2], 2'b00};
         case (f3[1:0])
            2'd0:    me.be = 4'b0001 << ea[1:0];
            2'd1:    me.be = 4'b0011 << ea[1:0];
            default: me.be = 4'b1111;
         endcase
         me.wdata = rs2 << (8 * ea[1:0]);
         mem_q.push_back(me);
      end
      oe.rd        = rd;
      oe.fault     = flt;
      oe.we        = (flt == 2'd0) && is_load && (rd != 5'd0);
      oe.value     = ((flt == 2'd0) && is_load) ? model_load(f3, ea[1:0], rdata) : 32'h0;
      oe.chk_value = is_load || (flt != 2'd0);
      out_q.push_back(oe);

      @(negedge clk);
      in_valid   = 1'b0;
      in_opcode  = 7'($urandom);
      in_funct3  = 3'($urandom);
      in_rd      = 5'($urandom);
      in_rs1_val = $urandom;
      in_rs2_val = $urandom;
      in_imm     = 12'($urandom);

      if (flt == 2'd0) begin
         me = mem_q.pop_front();
         for (int i = 0; i <= ack_wait; i++) begin
            if (i > 0) @(negedge clk);
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, me.we);
            chk("mem_addr", mem_addr, me.addr);
            chk("mem_be", mem_be, me.be);
            if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
            chk("out_valid_in_req", out_valid, 0);
         end
         mem_ack   = 1'b1;
         mem_rdata = rdata;
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
      end else begin
         chk("no_req_on_fault", mem_req, 0);
      end

      oe = out_q.pop_front();
      for (int i = 0; i <= ready_wait; i++) begin
         if (i > 0) @(negedge clk);
         chk("out_valid", out_valid, 1);
         chk("in_ready_resp", in_ready, 0);
         chk("mem_req_resp", mem_req, 0);
         chk("out_rd", out_rd, oe.rd);
         chk("out_we", out_we, oe.we);
         chk("out_fault", out_fault, oe.fault);
         if (oe.chk_value) chk("out_rd_value", out_rd_value, oe.value);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_after_resp", in_ready, 1);
      chk("out_valid_drop", out_valid, 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_opcode  = 7'd0;
      in_funct3  = 3'd0;
      in_rd      = 5'd0;
      in_rs1_val = 32'd0;
      in_rs2_val = 32'd0;
      in_imm     = 12'd0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'd0;
      out_ready  = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_rd_value", out_rd_value, 0);
      chk("rst_out_we", out_we, 0);
      chk("rst_out_fault", out_fault, 0);
      rst_n = 1'b1;

      // Stray ack while idle must be ignored.
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stray_ack_idle_valid", out_valid, 0);
      chk("stray_ack_idle_ready", in_ready, 1);

      //     op          f3    rd     rs1           rs2           imm      rdata         ack rdy
      run_op(7'b0000011, 3'd2, 5'd5,  32'h100,      32'h0,        12'h004, 32'hDEADBEEF, 0, 0); // LW
      run_op(7'b0000011, 3'd0, 5'd6,  32'h100,      32'h0,        12'h003, 32'h80FFFFFF, 0, 0); // LB
      run_op(7'b0000011, 3'd4, 5'd7,  32'h100,      32'h0,        12'h003, 32'h80FFFFFF, 1, 0); // LBU
      run_op(7'b0100011, 3'd1, 5'd9,  32'h200,      32'h1234ABCD, 12'hFFE, 32'h0,        3, 0); // SH
      run_op(7'b0000011, 3'd2, 5'd3,  32'h100,      32'h0,        12'h002, 32'h0,        0, 0); // LW misaligned
      run_op(7'b0110011, 3'd0, 5'd4,  32'h100,      32'h0,        12'h000, 32'h0,        0, 0); // not a mem op
      run_op(7'b0000011, 3'd2, 5'd0,  32'h300,      32'h0,        12'h000, 32'hCAFEF00D, 0, 5); // LW rd=0
      run_op(7'b0000011, 3'd1, 5'd10, 32'h400,      32'h0,        12'h002, 32'h80011234, 0, 1); // LH hi
      run_op(7'b0000011, 3'd5, 5'd11, 32'h400,      32'h0,        12'h000, 32'h80019234, 2, 0); // LHU lo
      run_op(7'b0100011, 3'd0, 5'd12, 32'h500,      32'h000000AB, 12'h001, 32'h0,        0, 0); // SB
      run_op(7'b0100011, 3'd2, 5'd13, 32'h600,      32'h89ABCDEF, 12'h7FC, 32'h0,        1, 0); // SW
      run_op(7'b0100011, 3'd3, 5'd14, 32'h600,      32'h0,        12'h000, 32'h0,        0, 0); // store f3 illegal
      run_op(7'b0000011, 3'd6, 5'd15, 32'h601,      32'h0,        12'h000, 32'h0,        0, 0); // illegal beats misalign
      run_op(7'b0000011, 3'd1, 5'd16, 32'h601,      32'h0,        12'h000, 32'h0,        0, 0); // LH misaligned
      run_op(7'b0000011, 3'd0, 5'd17, 32'hFFFFFFFF, 32'h0,        12'h001, 32'h11223344, 0, 0); // ea wraps to 0

      for (int k = 0; k < 10; k++) begin
         run_op((($urandom % 2) == 0) ? 7'b0000011 : 7'b0100011, 3'($urandom), 5'($urandom),
                $urandom, $urandom, 12'($urandom), $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      // Reset during REQ: mem_req drops without a clock edge, late ack ignored.
      @(negedge clk);
      in_valid   = 1'b1;
      in_opcode  = 7'b0000011;
      in_funct3  = 3'd2;
      in_rd      = 5'd1;
      in_rs1_val = 32'h700;
      in_imm     = 12'h000;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rstreq_req_high", mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstreq_req_async_drop", mem_req, 0);
      chk("rstreq_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 32'h55AA55AA;
      @(negedge clk);
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rstreq_no_valid", out_valid, 0);
         chk("rstreq_no_req", mem_req, 0);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_dmem_stage
`default_nettype wire

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- Data-memory stage that sits beside the execute stage, on the decode-to-execute/dmem path.
- Accepts decoded LOAD/STORE operations and computes the effective address (rs1 + sign-extended imm12).
- Drives a single-outstanding request/ack data-memory port, aligns and sign-extends load data, and hands a result to the writeback stage over a valid/ready handshake.
- Exactly one transaction in flight.

Parameters:
- XLEN, 32, data/register width.
- ADDR_W, 32, memory address width (low ADDR_W bits of the effective address are driven).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  decoded memory op present
- in_ready  out  1  stage can accept an op
- in_opcode  in  7  LOAD=7'b0000011, STORE=7'b0100011
- in_funct3  in  3  width/sign select
- in_rd  in  5  destination register
- in_rs1_val  in  XLEN  base register value
- in_rs2_val  in  XLEN  store data register value
- in_imm  in  12  offset
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_ack  in  1  request completed; mem_rdata valid this cycle for loads
- mem_rdata  in  XLEN  full read word
- out_valid  out  1  result for writeback
- out_ready  in  1  writeback accepts
- out_rd  out  5  destination register
- out_rd_value  out  XLEN  load result
- out_we  out  1  register write enable
- out_fault  out  2  0 none, 1 misaligned, 2 illegal

Behaviour:
- Clock and reset: single clock clk, rising edge. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, out_valid=0, out_rd=0, out_rd_value=0, out_we=0, out_fault=0.
- FSM states:
  - IDLE: in_ready=1.
  - REQ: mem_req=1. All mem_* outputs are held stable until mem_ack.
  - RESP: out_valid=1. All out_* outputs are held stable until out_ready.
- Accept: occurs on a rising edge with in_valid & in_ready. The stage latches the op and computes ea = in_rs1_val + sext(in_imm), modulo 2^XLEN.
- Legality check at accept:
  - Illegal: opcode is neither LOAD nor STORE; LOAD funct3 not in {000,001,010,100,101}; STORE funct3 not in {000,001,010}.
  - Misaligned: halfword with ea[0]=1; word with ea[1:0]!=0.
  - Illegal takes priority over misaligned.
  - A faulting op goes directly to RESP with out_fault set, out_we=0, out_rd_value=0, and issues no memory request.
- Legal op: goes to REQ on the next cycle.
  - mem_addr = {ea[ADDR_W-1:2],2'b00}.
  - mem_be: byte = 1<<ea[1:0]; half = 2'b11<<ea[1:0]; word = 4'hF.
  - mem_wdata = rs2 value shifted left by 8*ea[1:0] (word: unshifted).
- REQ handling:
  - mem_ack is allowed in the first cycle mem_req is high. On ack, go to RESP on the next edge.
  - For loads, capture mem_rdata on the ack edge.
  - Byte/half extraction uses ea[1:0]: LB/LH sign-extend, LBU/LHU zero-extend.
- Load-to-out_valid latency: 1 cycle after accept to mem_req, plus 1 cycle after ack to out_valid. With ack on the first REQ cycle, out_valid is asserted 2 cycles after accept.
- Outputs in RESP:
  - out_we = 1 for loads with rd != 0.
  - out_we = 0 for stores, rd = 0, and faults.
  - out_rd always carries the latched rd.
- RESP to IDLE: on out_valid & out_ready. Back-to-back accept is not allowed in that same edge (in_ready=0 in RESP), giving a minimum of 3 cycles per op.
- mem_ack while not in REQ is ignored.
- Asserting reset mid-REQ drops mem_req immediately (asynchronously). An ack arriving after reset release is ignored.
- in_* values are sampled only at accept; changes at other times have no effect.

Decomposition:
- Shared package (defs):
  - opcode constants OP_LOAD, OP_STORE;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum dmem_state_t {IDLE, REQ, RESP};
  - fault enum dmem_fault_t {FLT_NONE, FLT_MISALIGN, FLT_ILLEGAL}.
- Sub-module dmem_align: combinational lane logic.
  - Store direction: be and wdata from funct3, ea[1:0], rs2.
  - Load direction: extended result from funct3, ea[1:0], rdata.
  - Shared so that a future cache can reuse it.

Test Plan:
- LW, rs1=0x100, imm=4, mem_rdata=0xDEADBEEF, ack on first REQ cycle -> mem_addr=0x104, mem_be=4'hF; out_rd_value=0xDEADBEEF, out_we=1 two cycles after accept.
- LB/LBU at ea=0x103, rdata=0x80FFFFFF -> mem_be=4'b1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH, rs1=0x200, imm=-2 (0xFFE), rs2=0x1234ABCD, ack after 3 wait cycles -> mem_addr=0x1FC, mem_be=4'b1100, mem_wdata=0xABCD0000 held stable throughout; out_we=0.
- LW at ea=0x102 -> no mem_req ever, out_fault=1, out_we=0; opcode 7'b0110011 -> out_fault=2.
- LW with rd=0 and out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0, out_we=0; IDLE after out_ready.
- rst_n low during REQ -> mem_req=0 in the same cycle; a stray mem_ack after release produces no out_valid.
